// File: rtl/fetch_unit_if.sv
// fetch_unit_if: fetch-stage bus bundling hazard control, imem port and IF/ID outputs
interface fetch_unit_if #(
   parameter int N  = 64,
   parameter int AW = 6
);
   logic          stall_F;
   logic          pcsrc;
   logic [N-1:0]  branch_target;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_q;
   logic [N-1:0]  pc_F;
   logic [31:0]   instr_D;
   logic [N-1:0]  pc_D;
   logic          valid_D;
   logic          fetch_fault;
   modport master (
      input  stall_F, pcsrc, branch_target, imem_q,
      output imem_addr, pc_F, instr_D, pc_D, valid_D, fetch_fault
   );
   modport slave (
      output stall_F, pcsrc, branch_target, imem_q,
      input  imem_addr, pc_F, instr_D, pc_D, valid_D, fetch_fault
   );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: LEGv8 instruction fetch with PC, IF/ID register, stall, redirect/flush and range fault
module fetch_unit #(
   parameter int           N        = 64,
   parameter int           AW       = 6,
   parameter logic [N-1:0] RESET_PC = '0
) (
   input logic           clk,
   input logic           reset,
   fetch_unit_if.master  f
);
   typedef enum logic {BUBBLE, RUN} state_t;
   state_t        state, state_n;
   logic [N-1:0]  pc, pc_n, pc_d, pc_d_n;
   logic [31:0]   ir, ir_n;
   logic          fault, fault_n;
   logic          in_range;
   assign in_range      = pc[N-1:AW+2] == '0;
   assign f.imem_addr   = pc[AW+1:2];
   assign f.pc_F        = pc;
   assign f.instr_D     = ir;
   assign f.pc_D        = pc_d;
   assign f.valid_D     = state == RUN;
   assign f.fetch_fault = fault;
   // State register: PC, IF/ID contents, RUN/BUBBLE state and sticky fault
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= BUBBLE;
         pc    <= RESET_PC;
         pc_d  <= '0;
         ir    <= '0;
         fault <= 1'b0;
      end else begin
         state <= state_n;
         pc    <= pc_n;
         pc_d  <= pc_d_n;
         ir    <= ir_n;
         fault <= fault_n;
      end
   end
   // Next state: redirect flushes and beats stall; stall holds; else advance and capture
   always_comb begin
      state_n = state;
      pc_n    = pc;
      pc_d_n  = pc_d;
      ir_n    = ir;
      fault_n = fault;
      if (f.pcsrc) begin
         state_n = BUBBLE;
         pc_n    = {f.branch_target[N-1:2], 2'b00};
         pc_d_n  = '0;
         ir_n    = '0;
      end else if (!f.stall_F) begin
         state_n = in_range ? RUN : BUBBLE;
         pc_n    = pc + N'(4);
         pc_d_n  = pc;
         ir_n    = in_range ? f.imem_q : 32'h0;
         fault_n = fault | ~in_range;
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit
module tb_fetch_unit;
   localparam int N = 64, AW = 6;
   typedef struct {
      int           id;
      logic [N-1:0] pc;
      logic [31:0]  ir;
      logic [N-1:0] pcd;
      logic         v;
      logic         f;
   } exp_t;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [31:0] rom [2**AW];
   exp_t q[$];
   int total = 0, bad = 0, id = 0;
   event mon_ev;
   fetch_unit_if #(.N(N), .AW(AW)) bus();
   fetch_unit #(.N(N), .AW(AW), .RESET_PC('0)) dut (.clk(clk), .reset(reset), .f(bus));
   assign bus.imem_q = rom[bus.imem_addr];
   always #5 clk = ~clk;
   task automatic chk(string nm, int i, logic [N-1:0] got, logic [N-1:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL step%0d %s got=%h want=%h", i, nm, got, want);
      end
   endtask
   task automatic exp_push(logic [N-1:0] pc, logic [31:0] ir, logic [N-1:0] pcd, logic v, logic f);
      exp_t e;
      id++;
      e.id = id; e.pc = pc; e.ir = ir; e.pcd = pcd; e.v = v; e.f = f;
      q.push_back(e);
   endtask
   task automatic step(logic s, logic p, logic [N-1:0] bt,
                       logic [N-1:0] pc, logic [31:0] ir, logic [N-1:0] pcd, logic v, logic f);
      bus.stall_F = s;
      bus.pcsrc = p;
      bus.branch_target = bt;
      @(posedge clk);
      #1;
      exp_push(pc, ir, pcd, v, f);
   endtask
   initial begin
      exp_t e;
      forever begin
         @(negedge clk or mon_ev);
         while (q.size() > 0) begin
            e = q.pop_front();
            chk("pc_F", e.id, bus.pc_F, e.pc);
            chk("imem_addr", e.id, N'(bus.imem_addr), N'(e.pc[AW+1:2]));
            chk("instr_D", e.id, N'(bus.instr_D), N'(e.ir));
            chk("pc_D", e.id, bus.pc_D, e.pcd);
            chk("valid_D", e.id, N'(bus.valid_D), N'(e.v));
            chk("fetch_fault", e.id, N'(bus.fetch_fault), N'(e.f));
         end
      end
   end
   initial begin
      foreach (rom[i]) rom[i] = 32'h0;
      rom[0] = 32'hf8000000;
      rom[1] = 32'hf8008001;
      rom[2] = 32'hf8010002;
      rom[3] = 32'hd61f0300;
      bus.stall_F = 1'b0;
      bus.pcsrc = 1'b0;
      bus.branch_target = '0;
      #1 exp_push(64'h0, 32'h0, 64'h0, 1'b0, 1'b0);
      #11 reset = 1'b1;
      step(0, 0, 64'h0,  64'h4,  32'hf8000000, 64'h0, 1, 0);
      step(0, 0, 64'h0,  64'h8,  32'hf8008001, 64'h4, 1, 0);
      step(1, 0, 64'h0,  64'h8,  32'hf8008001, 64'h4, 1, 0);
      step(1, 0, 64'h0,  64'h8,  32'hf8008001, 64'h4, 1, 0);
      step(0, 0, 64'h0,  64'hc,  32'hf8010002, 64'h8, 1, 0);
      step(1, 1, 64'h6,  64'h4,  32'h0,        64'h0, 0, 0);
      step(0, 0, 64'h0,  64'h8,  32'hf8008001, 64'h4, 1, 0);
      step(0, 1, 64'hfc, 64'hfc, 32'h0,        64'h0, 0, 0);
      step(0, 0, 64'h0,  64'h100, 32'h0,       64'hfc, 1, 0);
      step(0, 0, 64'h0,  64'h104, 32'h0,       64'h100, 0, 1);
      step(0, 1, 64'h0,  64'h0,  32'h0,        64'h0, 0, 1);
      step(0, 0, 64'h0,  64'h4,  32'hf8000000, 64'h0, 1, 1);
      step(0, 1, 64'hffff_ffff_ffff_ffff, 64'hffff_ffff_ffff_fffc, 32'h0, 64'h0, 0, 1);
      step(0, 0, 64'h0,  64'h0,  32'h0, 64'hffff_ffff_ffff_fffc, 0, 1);
      step(0, 1, 64'h23, 64'h20, 32'h0,        64'h0, 0, 1);
      step(1, 0, 64'h0,  64'h20, 32'h0,        64'h0, 0, 1);
      @(negedge clk);
      #1 reset = 1'b0;
      #1 exp_push(64'h0, 32'h0, 64'h0, 1'b0, 1'b0);
      ->mon_ev;
      #3 reset = 1'b1;
      bus.stall_F = 1'b0;
      step(0, 1, 64'h200, 64'h200, 32'h0, 64'h0, 0, 0);
      step(1, 0, 64'h0,   64'h200, 32'h0, 64'h0, 0, 0);
      step(0, 0, 64'h0,   64'h204, 32'h0, 64'h200, 0, 1);
      step(0, 0, 64'h0,   64'h208, 32'h0, 64'h204, 0, 1);
      repeat (3) @(negedge clk);
      #1;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain pending=%0d want=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the pipelined LEGv8 core.
- Owns the PC register and drives the word address into the 64-word instruction ROM (imem).
- Captures the returned instruction into the IF/ID pipeline register.
- Handles stall, branch redirect with flush, and out-of-range fetch detection.

Parameters:
- N, 64: PC and branch-target width in bits.
- AW, 6: imem word-address width; ROM holds 2^AW words.
- RESET_PC, 0: PC value loaded at reset; must be 4-byte aligned.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- stall_F  input  1  hazard stall: hold PC and IF/ID contents.
- pcsrc  input  1  branch taken: redirect PC to branch_target.
- branch_target  input  N  byte address of the redirect target.
- imem_addr  output  AW  word address to imem; equals pc_F[AW+1:2].
- imem_q  input  32  instruction word from imem; combinational on imem_addr.
- pc_F  output  N  current fetch PC.
- instr_D  output  32  IF/ID instruction.
- pc_D  output  N  IF/ID PC of instr_D.
- valid_D  output  1  instr_D is a real instruction (0 means bubble).
- fetch_fault  output  1  sticky flag: a fetch was attempted outside ROM range.

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately, including mid-stall or mid-redirect):
  - pc_F=RESET_PC
  - instr_D=0, pc_D=0, valid_D=0
  - fetch_fault=0
- imem_addr=pc_F[AW+1:2], combinational. Latency from PC to instr_D is one clock.
- Range check: in_range = (pc_F[N-1:AW+2]==0).
- Per rising edge, priority high to low:
  1. pcsrc=1, whether or not stall_F is set:
     - pc_F <= {branch_target[N-1:2],2'b00}; low two bits are dropped, no fault.
     - IF/ID flushed: valid_D=0, instr_D=0, pc_D=0.
  2. stall_F=1, pcsrc=0: pc_F, instr_D, pc_D, valid_D all hold.
  3. Otherwise (normal advance):
     - pc_F <= pc_F+4, modulo 2^N; wrap from all-ones-aligned to 0 is legal.
     - If in_range: instr_D<=imem_q, pc_D<=pc_F, valid_D<=1.
     - If not in_range: instr_D<=0, pc_D<=pc_F, valid_D<=0, fetch_fault<=1.
- fetch_fault:
  - Set only in case 3 with in_range=0.
  - Stays set until reset.
  - A stalled or redirected cycle never sets it.
- Internal states, encoded by the value of valid_D:
  - RUN: valid_D=1 after a good fetch.
  - BUBBLE: valid_D=0 after reset, flush, or out-of-range fetch.
  - BUBBLE->RUN on the next unstalled, in-range, non-redirect edge.
- Last in-range word: pc_F=4*(2^AW-1) fetches normally. The next advance reaches PC=2^(AW+2), which is out of range.
- No combinational path from pcsrc or stall_F to imem_addr; imem_addr depends on pc_F only.

Test Plan (imem preloaded: word0=32'hf8000000, word1=32'hf8008001, word2=32'hf8010002, word3=32'hd61f0300, all others 0):
- Reset release, 3 free-running edges:
  - imem_addr sequence 0,1,2,3.
  - After edge 1: instr_D=f8000000, pc_D=0, valid_D=1.
  - After edge 3: instr_D=f8010002, pc_D=8.
- stall_F=1 for 2 edges with pc_F=8:
  - pc_F stays 8; instr_D stays f8008001, valid_D=1.
  - After release, next edge: instr_D=f8010002, pc_D=8, pc_F=12.
- pcsrc=1, branch_target=0x6, with stall_F=1 on the same edge:
  - pc_F=4, valid_D=0, instr_D=0.
  - Next edge: instr_D=f8008001, pc_D=4, valid_D=1.
- Redirect to 0xFC, then 2 edges:
  - First edge fetches word63: valid_D=1, pc_D=0xFC.
  - Second edge: pc_D=0x100, valid_D=0, fetch_fault=1.
  - fetch_fault stays 1 after a later redirect to 0.
- Redirect to 0xFFFF_FFFF_FFFF_FFFC, then 1 edge:
  - pc_F wraps to 0.
  - valid_D=0, fetch_fault=1, since the address is out of range.
- Assert reset mid-stall with pc_F=0x20, between clock edges:
  - pc_F=0, valid_D=0, fetch_fault=0 immediately, without a clock edge.
